// File: rtl/mo_mem_server_if.sv
// Engine-facing request/response bus of the MO memory server.
// The engine drives opcode/i/j/out_data/fin; the server answers on in_data.
interface mo_mem_server_if #(
  parameter int DW = 10,
  parameter int YW = 20
);
  logic [2:0]    opcode;
  logic [9:0]    i;
  logic [9:0]    j;
  logic [YW-1:0] out_data;
  logic          fin;
  logic [DW-1:0] in_data;

  modport master (output opcode, i, j, out_data, fin, input in_data);
  modport slave  (input opcode, i, j, out_data, fin, output in_data);
endinterface

// File: rtl/mo_mem_server.sv
// Operand/result store for the MO engine: combinational reads of N, R, A, X, B,
// registered Y writes, host preload and Y readback, sticky done/err flags.
module mo_mem_server #(
  parameter int MAX_N = 8,
  parameter int DW    = 10,
  parameter int YW    = 20
) (
  input  logic            clk,
  input  logic            reset,
  mo_mem_server_if.slave  eng,
  input  logic            load_en,
  input  logic [1:0]      load_sel,
  input  logic [9:0]      load_i,
  input  logic [9:0]      load_j,
  input  logic [DW-1:0]   load_data,
  input  logic [9:0]      rd_i,
  input  logic [9:0]      rd_j,
  output logic [YW-1:0]   rd_data,
  output logic [9:0]      y_count,
  output logic            done,
  output logic            err
);
  localparam int DEPTH = MAX_N * MAX_N;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_GET_N   = 3'b000;
  localparam logic [2:0] OP_GET_R   = 3'b001;
  localparam logic [2:0] OP_READ_A  = 3'b010;
  localparam logic [2:0] OP_READ_X  = 3'b011;
  localparam logic [2:0] OP_READ_B  = 3'b100;
  localparam logic [2:0] OP_WRITE_Y = 3'b101;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_X   = 2'd1;
  localparam logic [1:0] SEL_B   = 2'd2;
  localparam logic [1:0] SEL_DIM = 2'd3;

  // Full-width compare, so any nonzero upper index bit lands out of range.
  function automatic logic lt(input logic [9:0] idx, input int unsigned lim);
    return 32'(idx) < lim;
  endfunction

  function automatic logic [AW-1:0] flat(input logic [9:0] r, input logic [9:0] c);
    return AW'(32'(r) * 32'(MAX_N) + 32'(c));
  endfunction

  logic [DW-1:0] n_q, n_d, r_q, r_d;
  logic [9:0]    y_count_q, y_count_d;
  logic          done_q, done_d, err_q, err_d;
  logic [DW-1:0] a_q [DEPTH];
  logic [DW-1:0] x_q [DEPTH];
  logic [DW-1:0] b_q [DEPTH];
  logic [YW-1:0] y_q [DEPTH];

  logic [DW-1:0] in_data_c;
  logic          rd_oor;
  logic          wr_y_ok, wr_y_bad;
  logic          ld_in_range, ld_a, ld_x, ld_b, ld_n, ld_r, ld_sat, ld_bad;
  logic [DW-1:0] dim_val;
  logic [AW-1:0] req_addr, ld_addr;

  assign req_addr = flat(eng.i, eng.j);
  assign ld_addr  = flat(load_i, load_j);

  always_comb begin
    in_data_c = '0;
    rd_oor    = 1'b0;
    case (eng.opcode)
      OP_GET_N: in_data_c = n_q;
      OP_GET_R: in_data_c = r_q;
      OP_READ_A:
        if (lt(eng.i, 32'(n_q)) && lt(eng.j, 32'(r_q))) in_data_c = a_q[req_addr];
        else rd_oor = 1'b1;
      OP_READ_X:
        if (lt(eng.i, 32'(r_q)) && lt(eng.j, 32'(n_q))) in_data_c = x_q[req_addr];
        else rd_oor = 1'b1;
      OP_READ_B:
        if (lt(eng.i, 32'(n_q)) && lt(eng.j, 32'(n_q))) in_data_c = b_q[req_addr];
        else rd_oor = 1'b1;
      default: in_data_c = '0;
    endcase
  end

  assign eng.in_data = in_data_c;

  always_comb begin
    rd_data = '0;
    if (lt(rd_i, MAX_N) && lt(rd_j, MAX_N)) rd_data = y_q[flat(rd_i, rd_j)];
  end

  // Y writes are only accepted inside the N x N window and before completion.
  assign wr_y_ok  = (eng.opcode == OP_WRITE_Y) && lt(eng.i, 32'(n_q)) &&
                    lt(eng.j, 32'(n_q)) && !done_q;
  assign wr_y_bad = (eng.opcode == OP_WRITE_Y) && !wr_y_ok;

  assign ld_in_range = lt(load_i, MAX_N) && lt(load_j, MAX_N);
  assign ld_a   = load_en && (load_sel == SEL_A) && ld_in_range;
  assign ld_x   = load_en && (load_sel == SEL_X) && ld_in_range;
  assign ld_b   = load_en && (load_sel == SEL_B) && ld_in_range;
  assign ld_n   = load_en && (load_sel == SEL_DIM) && (load_i == 10'd0);
  assign ld_r   = load_en && (load_sel == SEL_DIM) && (load_i == 10'd1);
  assign ld_sat = 32'(load_data) > 32'(MAX_N);
  assign dim_val = ld_sat ? DW'(MAX_N) : load_data;
  assign ld_bad = load_en && (((load_sel != SEL_DIM) && !ld_in_range) ||
                              ((load_sel == SEL_DIM) && (!lt(load_i, 2) || ld_sat)));

  always_comb begin
    n_d       = ld_n ? dim_val : n_q;
    r_d       = ld_r ? dim_val : r_q;
    done_d    = done_q | eng.fin;
    err_d     = err_q | rd_oor | wr_y_bad | ld_bad;
    y_count_d = y_count_q;
    if (wr_y_ok && (y_count_q != 10'h3FF)) y_count_d = y_count_q + 10'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q       <= '0;
      r_q       <= '0;
      y_count_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      n_q       <= n_d;
      r_q       <= r_d;
      y_count_q <= y_count_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Storage must clear on reset, so it lives in registers rather than RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        a_q[k] <= '0;
        x_q[k] <= '0;
        b_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      if (ld_a)    a_q[ld_addr]  <= load_data;
      if (ld_x)    x_q[ld_addr]  <= load_data;
      if (ld_b)    b_q[ld_addr]  <= load_data;
      if (wr_y_ok) y_q[req_addr] <= eng.out_data;
    end
  end

  assign y_count = y_count_q;
  assign done    = done_q;
  assign err     = err_q;
endmodule

// File: tb/tb_mo_mem_server.sv
// Self-checking bench for mo_mem_server: directed scenarios plus randomized
// traffic compared against a behavioural model of the operand store.
module tb_mo_mem_server;
  localparam int MAX_N = 8;
  localparam int DW    = 10;
  localparam int YW    = 20;

  localparam logic [2:0] GET_N = 3'b000, GET_R = 3'b001, RD_A = 3'b010, RD_X = 3'b011,
                         RD_B = 3'b100, WR_Y = 3'b101, NOP = 3'b110;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [1:0]    load_sel;
  logic [9:0]    load_i, load_j, rd_i, rd_j, y_count;
  logic [DW-1:0] load_data;
  logic [YW-1:0] rd_data;
  logic          done, err;

  always #5 clk = ~clk;

  mo_mem_server_if #(.DW(DW), .YW(YW)) bus ();

  mo_mem_server #(.MAX_N(MAX_N), .DW(DW), .YW(YW)) dut (
    .clk       (clk),
    .reset     (reset),
    .eng       (bus),
    .load_en   (load_en),
    .load_sel  (load_sel),
    .load_i    (load_i),
    .load_j    (load_j),
    .load_data (load_data),
    .rd_i      (rd_i),
    .rd_j      (rd_j),
    .rd_data   (rd_data),
    .y_count   (y_count),
    .done      (done),
    .err       (err)
  );

  // Reference state of the store
  int unsigned m_n, m_r, m_cnt;
  bit          m_done, m_err;
  int unsigned m_a [MAX_N][MAX_N];
  int unsigned m_x [MAX_N][MAX_N];
  int unsigned m_b [MAX_N][MAX_N];
  int unsigned m_y [MAX_N][MAX_N];

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] last_in;
  logic [YW-1:0] last_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_r = 0; m_cnt = 0; m_done = 0; m_err = 0;
    for (int r = 0; r < MAX_N; r++)
      for (int c = 0; c < MAX_N; c++) begin
        m_a[r][c] = 0; m_x[r][c] = 0; m_b[r][c] = 0; m_y[r][c] = 0;
      end
  endtask

  function automatic int unsigned model_read(input logic [2:0] op, input int unsigned ii,
                                             input int unsigned jj, output bit oor);
    oor = 0;
    case (op)
      GET_N: return m_n;
      GET_R: return m_r;
      RD_A: begin if (ii < m_n && jj < m_r) return m_a[ii][jj]; oor = 1; end
      RD_X: begin if (ii < m_r && jj < m_n) return m_x[ii][jj]; oor = 1; end
      RD_B: begin if (ii < m_n && jj < m_n) return m_b[ii][jj]; oor = 1; end
      default: ;
    endcase
    return 0;
  endfunction

  task automatic model_edge(input logic [2:0] op, input int unsigned ii, input int unsigned jj,
                            input int unsigned od, input bit f, input bit le,
                            input int unsigned ls, input int unsigned li, input int unsigned lj,
                            input int unsigned ld);
    bit oor;
    bit e;
    int unsigned v;
    void'(model_read(op, ii, jj, oor));
    e = oor;
    if (op == WR_Y) begin
      if (!m_done && ii < m_n && jj < m_n) begin
        m_y[ii][jj] = od;
        if (m_cnt < 1023) m_cnt++;
      end else e = 1;
    end
    if (le) begin
      if (ls == 3) begin
        if (li < 2) begin
          v = (ld > MAX_N) ? MAX_N : ld;
          if (ld > MAX_N) e = 1;
          if (li == 0) m_n = v; else m_r = v;
        end else e = 1;
      end else if (li < MAX_N && lj < MAX_N) begin
        case (ls)
          0: m_a[li][lj] = ld;
          1: m_x[li][lj] = ld;
          default: m_b[li][lj] = ld;
        endcase
      end else e = 1;
    end
    if (f) m_done = 1;
    if (e) m_err = 1;
  endtask

  // One bus cycle, entered and left on a falling edge.
  task automatic do_cycle(input logic [2:0] op, input logic [9:0] ii, input logic [9:0] jj,
                          input logic [YW-1:0] od, input logic f, input logic le,
                          input logic [1:0] ls, input logic [9:0] li, input logic [9:0] lj,
                          input logic [DW-1:0] ld, input logic [9:0] ri, input logic [9:0] rj);
    bit oor;
    int unsigned exp_in, exp_rd;
    bus.opcode = op; bus.i = ii; bus.j = jj; bus.out_data = od; bus.fin = f;
    load_en = le; load_sel = ls; load_i = li; load_j = lj; load_data = ld;
    rd_i = ri; rd_j = rj;
    #1;
    exp_in = model_read(op, ii, jj, oor);
    exp_rd = (ri < MAX_N && rj < MAX_N) ? m_y[ri][rj] : 0;
    last_in = bus.in_data;
    last_rd = rd_data;
    check_eq("in_data", bus.in_data, exp_in);
    check_eq("rd_data", rd_data, exp_rd);
    @(posedge clk);
    model_edge(op, ii, jj, od, f, le, ls, li, lj, ld);
    #1;
    check_eq("err", err, m_err);
    check_eq("done", done, m_done);
    check_eq("y_count", y_count, m_cnt);
    $display("op=%0d i=%0d j=%0d od=%0d fin=%0b ld=%0b sel=%0d li=%0d lj=%0d ldat=%0d in=%0d rd=%0d cnt=%0d done=%0b err=%0b",
             op, ii, jj, od, f, le, ls, li, lj, ld, last_in, last_rd, y_count, done, err);
    @(negedge clk);
  endtask

  task automatic req(input logic [2:0] op, input logic [9:0] ii, input logic [9:0] jj,
                     input logic [YW-1:0] od);
    do_cycle(op, ii, jj, od, 1'b0, 1'b0, 2'd0, 10'd0, 10'd0, '0, 10'd0, 10'd0);
  endtask

  task automatic load(input logic [1:0] ls, input logic [9:0] li, input logic [9:0] lj,
                      input logic [DW-1:0] ld);
    do_cycle(NOP, 10'd0, 10'd0, '0, 1'b0, 1'b1, ls, li, lj, ld, 10'd0, 10'd0);
  endtask

  task automatic peek(input logic [9:0] ri, input logic [9:0] rj);
    do_cycle(NOP, 10'd0, 10'd0, '0, 1'b0, 1'b0, 2'd0, 10'd0, 10'd0, '0, ri, rj);
  endtask

  task automatic rst_dut();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  function automatic logic [9:0] rnd_idx();
    if ($urandom_range(0, 15) == 15) return 10'($urandom);
    return 10'($urandom_range(0, 9));
  endfunction

  initial begin
    int unsigned acc, av, nv, rv;
    logic [1:0] sel;
    bus.opcode = NOP; bus.i = '0; bus.j = '0; bus.out_data = '0; bus.fin = 1'b0;
    load_en = 1'b0; load_sel = '0; load_i = '0; load_j = '0; load_data = '0;
    rd_i = '0; rd_j = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    req(GET_N, 10'd0, 10'd0, '0);
    check_eq("reset_n", last_in, 0);
    check_eq("reset_err", err, 0);

    // Dimension reads
    load(2'd3, 10'd0, 10'd0, 10'd2);
    load(2'd3, 10'd1, 10'd0, 10'd3);
    req(GET_N, 10'd0, 10'd0, '0); check_eq("get_n", last_in, 2);
    req(GET_R, 10'd0, 10'd0, '0); check_eq("get_r", last_in, 3);
    check_eq("dim_err", err, 0);

    // Element reads and an out-of-range read
    load(2'd0, 10'd1, 10'd2, 10'd7);
    load(2'd1, 10'd2, 10'd1, 10'd5);
    load(2'd2, 10'd1, 10'd1, 10'd9);
    req(RD_A, 10'd1, 10'd2, '0); check_eq("read_a", last_in, 7);
    req(RD_X, 10'd2, 10'd1, '0); check_eq("read_x", last_in, 5);
    req(RD_B, 10'd1, 10'd1, '0); check_eq("read_b", last_in, 9);
    check_eq("reads_err", err, 0);
    req(RD_A, 10'd2, 10'd0, '0); check_eq("oor_data", last_in, 0);
    check_eq("oor_err", err, 1);

    // Load and read of the same entry in one cycle
    do_cycle(RD_A, 10'd1, 10'd2, '0, 1'b0, 1'b1, 2'd0, 10'd1, 10'd2, 10'd100, 10'd0, 10'd0);
    check_eq("same_cyc_old", last_in, 7);
    req(RD_A, 10'd1, 10'd2, '0); check_eq("same_cyc_new", last_in, 100);

    // Write path
    rst_dut();
    load(2'd3, 10'd0, 10'd0, 10'd2);
    req(WR_Y, 10'd0, 10'd0, 20'd11);
    req(WR_Y, 10'd0, 10'd1, 20'd22);
    req(WR_Y, 10'd1, 10'd0, 20'd33);
    req(WR_Y, 10'd1, 10'd1, 20'd1048575);
    peek(10'd0, 10'd0); check_eq("y00", last_rd, 11);
    peek(10'd0, 10'd1); check_eq("y01", last_rd, 22);
    peek(10'd1, 10'd0); check_eq("y10", last_rd, 33);
    peek(10'd1, 10'd1); check_eq("y11", last_rd, 1048575);
    check_eq("wr_count", y_count, 4);

    // Full run with the bench acting as the engine: Y = A*X + B
    rst_dut();
    load(2'd3, 10'd0, 10'd0, 10'd2);
    load(2'd3, 10'd1, 10'd0, 10'd2);
    load(2'd0, 10'd0, 10'd0, 10'd1); load(2'd0, 10'd0, 10'd1, 10'd2);
    load(2'd0, 10'd1, 10'd0, 10'd3); load(2'd0, 10'd1, 10'd1, 10'd4);
    load(2'd1, 10'd0, 10'd0, 10'd5); load(2'd1, 10'd0, 10'd1, 10'd6);
    load(2'd1, 10'd1, 10'd0, 10'd7); load(2'd1, 10'd1, 10'd1, 10'd8);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) load(2'd2, 10'(r), 10'(c), 10'd1);
    req(GET_N, 10'd0, 10'd0, '0); nv = last_in;
    req(GET_R, 10'd0, 10'd0, '0); rv = last_in;
    for (int r = 0; r < nv; r++)
      for (int c = 0; c < nv; c++) begin
        req(RD_B, 10'(r), 10'(c), '0);
        acc = last_in;
        for (int k = 0; k < rv; k++) begin
          req(RD_A, 10'(r), 10'(k), '0); av = last_in;
          req(RD_X, 10'(k), 10'(c), '0); acc += av * last_in;
        end
        req(WR_Y, 10'(r), 10'(c), YW'(acc));
      end
    do_cycle(NOP, 10'd0, 10'd0, '0, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0, '0, 10'd0, 10'd0);
    peek(10'd0, 10'd0); check_eq("run_y00", last_rd, 20);
    peek(10'd0, 10'd1); check_eq("run_y01", last_rd, 23);
    peek(10'd1, 10'd0); check_eq("run_y10", last_rd, 44);
    peek(10'd1, 10'd1); check_eq("run_y11", last_rd, 51);
    check_eq("run_done", done, 1);
    check_eq("run_count", y_count, 4);
    check_eq("run_err", err, 0);

    // Write after completion is ignored and flagged
    req(WR_Y, 10'd0, 10'd0, 20'd999);
    peek(10'd0, 10'd0); check_eq("post_done_y", last_rd, 20);
    check_eq("post_done_err", err, 1);

    // Overwrite of the same address before completion
    rst_dut();
    load(2'd3, 10'd0, 10'd0, 10'd2);
    req(WR_Y, 10'd1, 10'd1, 20'd5);
    req(WR_Y, 10'd1, 10'd1, 20'd6);
    peek(10'd1, 10'd1); check_eq("overwrite_y", last_rd, 6);
    check_eq("overwrite_cnt", y_count, 2);

    // Asynchronous reset asserted between edges
    bus.opcode = GET_N; rd_i = 10'd1; rd_j = 10'd1;
    #1;
    check_eq("pre_rst_n", bus.in_data, 2);
    check_eq("pre_rst_y", rd_data, 6);
    #1 reset = 1'b1;
    #1;
    check_eq("arst_in", bus.in_data, 0);
    check_eq("arst_rd", rd_data, 0);
    check_eq("arst_cnt", y_count, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_err", err, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    req(GET_N, 10'd0, 10'd0, '0); check_eq("post_rst_n", last_in, 0);
    check_eq("post_rst_cnt", y_count, 0);

    // Dimension saturation and y_count saturation
    load(2'd3, 10'd0, 10'd0, 10'd9);
    req(GET_N, 10'd0, 10'd0, '0); check_eq("n_sat", last_in, MAX_N);
    check_eq("n_sat_err", err, 1);
    load(2'd3, 10'd0, 10'd0, 10'd1);
    repeat (1030) req(WR_Y, 10'd0, 10'd0, YW'($urandom));
    check_eq("cnt_sat", y_count, 1023);

    // Randomized traffic
    for (int blk = 0; blk < 4; blk++) begin
      rst_dut();
      load(2'd3, 10'd0, 10'd0, DW'($urandom_range(1, MAX_N)));
      load(2'd3, 10'd1, 10'd0, DW'($urandom_range(1, MAX_N)));
      for (int t = 0; t < 150; t++) begin
        sel = 2'($urandom_range(0, 3));
        do_cycle(3'($urandom_range(0, 7)), rnd_idx(), rnd_idx(), YW'($urandom),
                 ($urandom_range(0, 99) == 0), 1'($urandom), sel,
                 (sel == 2'd3) ? 10'($urandom_range(0, 2)) : rnd_idx(), rnd_idx(),
                 (sel == 2'd3) ? DW'($urandom_range(0, 10)) : DW'($urandom),
                 rnd_idx(), rnd_idx());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
